// File: rtl/snake_pkg.sv
// Shared direction codes, helpers and default timing for the snake direction controller.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam int unsigned TICK_DIV_DEF     = 32'd12_500_000;
  localparam int unsigned STEP_DIV_DEF     = 32'd250_000;
  localparam int unsigned MIN_DIV_DEF      = 32'd3_000_000;
  localparam int unsigned START_LEN_DEF    = 32'd5;
  localparam int unsigned DEBOUNCE_CYC_DEF = 32'd500_000;

  // Opposite heading differs only in the upper code bit.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// Two-flop synchroniser, level debouncer and rising-edge press pulse for one button.
module snake_debounce
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;

  // The press pulse is raised on the same edge the debounced level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
        press <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced player buttons into a queued direction and a length-dependent move tick.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STEP_DIV     = STEP_DIV_DEF,
  parameter int unsigned MIN_DIV      = MIN_DIV_DEF,
  parameter int unsigned START_LEN    = START_LEN_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       btn_pause,
  input  logic [6:0] snake_length,
  input  logic       game_over,
  output logic [1:0] direction,
  output logic       move_tick,
  output logic       paused
);

  logic [3:0]  dir_press;
  logic        pause_press;

  for (genvar i = 0; i < 4; i++) begin : g_dir_btn
    snake_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn[i]),
      .press (dir_press[i])
    );
  end

  snake_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_pause),
    .press (pause_press)
  );

  logic [31:0] len_ext;
  logic [31:0] excess;
  logic [31:0] reduction;
  logic [31:0] base;
  logic [31:0] period;
  logic [31:0] count;

  assign len_ext   = {25'd0, snake_length};
  assign excess    = (len_ext > START_LEN) ? len_ext - START_LEN : 32'd0;
  assign reduction = STEP_DIV * excess;
  assign base      = (reduction >= TICK_DIV) ? 32'd0 : TICK_DIV - reduction;
  assign period    = (base < MIN_DIV) ? MIN_DIV : base;

  logic        running;
  logic        tick_due;

  assign running  = !paused && !game_over;
  assign tick_due = running && (count >= period - 32'd1);

  logic [1:0]  q0;
  logic [1:0]  q1;
  logic [1:0]  q_cnt;
  logic [1:0]  last;
  logic        pop;
  logic [1:0]  cnt_after_pop;
  logic [1:0]  cand;
  logic        req;
  logic        accept;
  logic [1:0]  q0_n;
  logic [1:0]  q1_n;
  logic [1:0]  q_cnt_n;

  assign last          = (q_cnt == 2'd0) ? direction : ((q_cnt == 2'd1) ? q0 : q1);
  assign pop           = tick_due && (q_cnt != 2'd0);
  assign cnt_after_pop = q_cnt - {1'b0, pop};
  assign req           = |dir_press;

  always_comb begin
    cand = DIR_UP;
    if (dir_press[0])      cand = DIR_UP;
    else if (dir_press[1]) cand = DIR_RIGHT;
    else if (dir_press[2]) cand = DIR_DOWN;
    else if (dir_press[3]) cand = DIR_LEFT;
  end

  assign accept = req && running && (cnt_after_pop != 2'd2) &&
                  (cand != last) && (cand != opposite(last));

  // Pop is applied first, then the accepted request lands behind whatever remains.
  always_comb begin
    q0_n    = q0;
    q1_n    = q1;
    q_cnt_n = q_cnt;
    if (pop) begin
      q0_n    = q1;
      q_cnt_n = q_cnt - 2'd1;
    end
    if (accept) begin
      if (q_cnt_n == 2'd0) q0_n = cand;
      else                 q1_n = cand;
      q_cnt_n = q_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      direction <= DIR_UP;
      move_tick <= 1'b0;
      paused    <= 1'b0;
      count     <= 32'd0;
      q0        <= DIR_UP;
      q1        <= DIR_UP;
      q_cnt     <= 2'd0;
    end else begin
      move_tick <= 1'b0;
      if (pause_press && !game_over) paused <= !paused;
      if (tick_due) begin
        count     <= 32'd0;
        move_tick <= 1'b1;
        if (pop) direction <= q0;
      end else if (running) begin
        count <= count + 32'd1;
      end
      q0    <= q0_n;
      q1    <= q1_n;
      q_cnt <= q_cnt_n;
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with shortened timing (period 20, debounce 4).
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       btn_pause = 1'b0;
  logic [6:0] snake_length = 7'd5;
  logic       game_over = 1'b0;
  logic [1:0] direction;
  logic       move_tick;
  logic       paused;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_dir_ctrl #(
    .TICK_DIV     (20),
    .STEP_DIV     (2),
    .MIN_DIV      (8),
    .START_LEN    (5),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .btn_pause    (btn_pause),
    .snake_length (snake_length),
    .game_over    (game_over),
    .direction    (direction),
    .move_tick    (move_tick),
    .paused       (paused)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!move_tick && n < 100);
  endtask

  task automatic press(input logic [3:0] m, input logic p, input int hold);
    btn = m;
    btn_pause = p;
    repeat (hold) step();
    btn = 4'd0;
    btn_pause = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    snake_length = 7'd5;
    repeat (3) step();
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL reset_dir got %0d want 0", direction); end
    checks++; if (move_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0d want 0", move_tick); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %0d want 0", paused); end
    reset = 1'b0;
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL first_tick_delay got %0d want 20", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL first_tick_dir got %0d want 0", direction); end
    step();
    checks++; if (move_tick !== 1'b0) begin errors++; $display("FAIL tick_width got %0d want 0", move_tick); end
    wait_tick(n);
    checks++; if (n !== 19) begin errors++; $display("FAIL second_tick_delay got %0d want 19", n); end
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL period_base got %0d want 20", n); end
  endtask

  task automatic test_reject();
    int n;
    press(4'b0100, 1'b0, 8);
    wait_tick(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL reject_rev_delay got %0d want 12", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL reject_reverse got %0d want 0", direction); end
    press(4'b0001, 1'b0, 8);
    wait_tick(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL reject_same_delay got %0d want 12", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL reject_same got %0d want 0", direction); end
  endtask

  task automatic test_request();
    int n;
    press(4'b1000, 1'b0, 2);
    wait_tick(n);
    checks++; if (n !== 18) begin errors++; $display("FAIL glitch_delay got %0d want 18", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL glitch_dir got %0d want 0", direction); end
    press(4'b0010, 1'b0, 10);
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL queued_not_applied got %0d want 0", direction); end
    wait_tick(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL request_delay got %0d want 10", n); end
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL request_dir got %0d want 1", direction); end
  endtask

  task automatic test_queue_full();
    int n;
    press(4'b0100, 1'b0, 6);
    press(4'b1000, 1'b0, 6);
    press(4'b0001, 1'b0, 6);
    wait_tick(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL qfull_delay got %0d want 2", n); end
    checks++; if (direction !== 2'b10) begin errors++; $display("FAIL qfull_first got %0d want 2", direction); end
    wait_tick(n);
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL qfull_second got %0d want 3", direction); end
    wait_tick(n);
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL qfull_dropped got %0d want 3", direction); end
    press(4'b0001, 1'b0, 6);
    press(4'b0100, 1'b0, 6);
    wait_tick(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL tail_rev_delay got %0d want 8", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL tail_rev_first got %0d want 0", direction); end
    wait_tick(n);
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL tail_rev_reject got %0d want 0", direction); end
  endtask

  task automatic test_priority();
    int n;
    press(4'b1010, 1'b0, 6);
    wait_tick(n);
    checks++; if (n !== 14) begin errors++; $display("FAIL prio_delay got %0d want 14", n); end
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL prio_dir got %0d want 1", direction); end
    wait_tick(n);
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL prio_drop got %0d want 1", direction); end
  endtask

  task automatic test_speed();
    int n;
    snake_length = 7'd9;
    wait_tick(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL len9_first got %0d want 12", n); end
    wait_tick(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL len9_period got %0d want 12", n); end
    snake_length = 7'd20;
    wait_tick(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL len20_first got %0d want 8", n); end
    wait_tick(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL len20_period got %0d want 8", n); end
    snake_length = 7'd3;
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL len3_period got %0d want 20", n); end
    snake_length = 7'd5;
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL len5_period got %0d want 20", n); end
    repeat (15) step();
    snake_length = 7'd20;
    wait_tick(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL shrink_fire got %0d want 1", n); end
    snake_length = 7'd5;
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL after_shrink got %0d want 20", n); end
  endtask

  task automatic test_pause();
    int n;
    int ticks;
    repeat (3) step();
    press(4'b0000, 1'b1, 6);
    step();
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on got %0d want 1", paused); end
    press(4'b0100, 1'b0, 8);
    ticks = 0;
    repeat (22) begin
      step();
      if (move_tick) ticks++;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL pause_ticks got %0d want 0", ticks); end
    press(4'b0000, 1'b1, 6);
    step();
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off got %0d want 0", paused); end
    wait_tick(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL resume_delay got %0d want 10", n); end
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL pause_req_drop got %0d want 1", direction); end
  endtask

  task automatic test_game_over();
    int ticks;
    game_over = 1'b1;
    press(4'b0000, 1'b1, 6);
    ticks = 0;
    repeat (34) begin
      step();
      if (move_tick) ticks++;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL gameover_ticks got %0d want 0", ticks); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL gameover_pause got %0d want 0", paused); end
    checks++; if (direction !== 2'b01) begin errors++; $display("FAIL gameover_dir got %0d want 1", direction); end
  endtask

  task automatic test_reset_mid();
    int n;
    reset = 1'b1;
    game_over = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL rst_restart got %0d want 20", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL rst_restart_dir got %0d want 0", direction); end
    press(4'b0010, 1'b1, 6);
    repeat (3) step();
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pre_rst_paused got %0d want 1", paused); end
    reset = 1'b1;
    repeat (2) step();
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL mid_rst_paused got %0d want 0", paused); end
    checks++; if (move_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got %0d want 0", move_tick); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL mid_rst_dir got %0d want 0", direction); end
    reset = 1'b0;
    wait_tick(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL post_rst_delay got %0d want 20", n); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL queue_cleared got %0d want 0", direction); end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_request();
    test_queue_full();
    test_priority();
    test_speed();
    test_pause();
    test_game_over();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
